mem_access: RTL and testbench

Memory-access stage sitting directly downstream of `ex`. Consumes the ex/mem latch contents (memory opcode, effective address, store data, destination register) and performs loads/stores over the byte-serial memory-controller port. Stalls the pipeline for the duration of each access, then drives the write-back value to the mem/wb latch. Non-memory results pass straight through.

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/mem_access_ld_ext.sv | 23 ++
 rtl/mem_access.sv | 143 ++++++++++++++
 tb/tb_mem_access.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared opcode encodings, FSM state encodings and small decode helpers
//   for the memory-access stage. Opcode values match the ex stage.
package mem_access_pkg;

  localparam int OpCodeLen = 4;
  typedef logic [OpCodeLen-1:0] op_t;

  localparam op_t MEM_NOP = 4'h0;
  localparam op_t EX_LB   = 4'h1;
  localparam op_t EX_LH   = 4'h2;
  localparam op_t EX_LW   = 4'h3;
  localparam op_t EX_LBU  = 4'h4;
  localparam op_t EX_LHU  = 4'h5;
  localparam op_t EX_SB   = 4'h6;
  localparam op_t EX_SH   = 4'h7;
  localparam op_t EX_SW   = 4'h8;

  localparam logic [1:0] MA_IDLE = 2'd0;
  localparam logic [1:0] MA_BUSY = 2'd1;
  localparam logic [1:0] MA_DONE = 2'd2;

  localparam logic        True  = 1'b1;
  localparam logic        False = 1'b0;
  localparam logic [31:0] Zero  = 32'h0;

  function automatic logic is_load(input op_t op);
    return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
           (op == EX_LBU) || (op == EX_LHU);
  endfunction

  function automatic logic is_store(input op_t op);
    return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
  endfunction

  // Index of the final byte of the access: 0/1/3 for byte/half/word.
  function automatic logic [1:0] op_last(input op_t op);
    case (op)
      EX_LH, EX_LHU, EX_SH: return 2'd1;
      EX_LW, EX_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ld_ext.sv
// ld_ext
//   Combinational load extension of the assembled little-endian buffer.
//   Ports: op (latched load opcode), raw (assembled bytes), value (result).
module ld_ext
  import mem_access_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] raw,
  output logic [31:0] value
);

  always_comb begin
    value = raw;
    case (op)
      EX_LB:   value = {{24{raw[7]}}, raw[7:0]};
      EX_LBU:  value = {24'h0, raw[7:0]};
      EX_LH:   value = {{16{raw[15]}}, raw[15:0]};
      EX_LHU:  value = {16'h0, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   Memory-access pipeline stage. Serialises loads/stores into byte
//   requests on the memory-controller port, stalling upstream for the
//   duration, then presents the write-back value to mem/wb.
//   Ports:
//     clk, rst_n                      clock, synchronous active-low reset
//     aluop_i/addr_i/data_i/rd_*_i    ex/mem latch contents
//     rd_addr_o/rd_enable_o/rd_data_o mem/wb write-back
//     stall_req                       holds ex/mem and upstream latches
//     mc_req/mc_we/mc_addr/mc_wdata   byte request to memory controller
//     mc_ack/mc_rdata                 byte completion and read data
//
//   state   | meaning
//   MA_IDLE | pass-through; memory op is captured on the edge
//   MA_BUSY | issuing byte idx of the access, waiting for mc_ack
//   MA_DONE | one cycle presenting the load result, stall released
module mem_access
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OpCodeLen-1:0] aluop_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 rd_enable_i,
  output logic [4:0]           rd_addr_o,
  output logic                 rd_enable_o,
  output logic [31:0]          rd_data_o,
  output logic                 stall_req,
  output logic                 mc_req,
  output logic                 mc_we,
  output logic [31:0]          mc_addr,
  output logic [7:0]           mc_wdata,
  input  logic                 mc_ack,
  input  logic [7:0]           mc_rdata
);

  logic [1:0]  state;
  op_t         op;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        rd_en;
  logic [1:0]  idx;
  logic [1:0]  last;
  logic [31:0] ld_buf;
  logic [31:0] ld_value;

  logic in_mem;
  assign in_mem = is_load(aluop_i) || is_store(aluop_i);

  ld_ext u_ld_ext (
    .op    (op),
    .raw   (ld_buf),
    .value (ld_value)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= MA_IDLE;
      op     <= MEM_NOP;
      base   <= Zero;
      wdata  <= Zero;
      rd     <= 5'd0;
      rd_en  <= False;
      idx    <= 2'd0;
      last   <= 2'd0;
      ld_buf <= Zero;
    end else begin
      case (state)
        MA_IDLE: begin
          if (in_mem) begin
            op     <= aluop_i;
            base   <= addr_i;
            wdata  <= data_i;
            rd     <= rd_addr_i;
            rd_en  <= rd_enable_i;
            idx    <= 2'd0;
            last   <= op_last(aluop_i);
            ld_buf <= Zero;
            state  <= MA_BUSY;
          end
        end
        MA_BUSY: begin
          if (mc_ack) begin
            if (is_load(op)) begin
              ld_buf[{idx, 3'b000} +: 8] <= mc_rdata;
            end
            if (idx == last) begin
              state <= MA_DONE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        MA_DONE: state <= MA_IDLE;
        default: state <= MA_IDLE;
      endcase
    end
  end

  // Request outputs are decoded from registered state only, so a
  // combinational mc_ack path from the controller cannot loop back.
  always_comb begin
    rd_addr_o   = 5'd0;
    rd_enable_o = False;
    rd_data_o   = Zero;
    stall_req   = False;
    mc_req      = False;
    mc_we       = False;
    mc_addr     = Zero;
    mc_wdata    = 8'h00;
    case (state)
      MA_IDLE: begin
        if (in_mem) begin
          stall_req = True;
        end else begin
          rd_addr_o   = rd_addr_i;
          rd_enable_o = rd_enable_i;
          rd_data_o   = data_i;
        end
      end
      MA_BUSY: begin
        stall_req = True;
        mc_req    = True;
        mc_we     = is_store(op);
        mc_addr   = base + {30'h0, idx};
        mc_wdata  = wdata[{idx, 3'b000} +: 8];
        rd_addr_o = rd;
      end
      MA_DONE: begin
        rd_addr_o = rd;
        if (is_load(op)) begin
          rd_enable_o = rd_en;
          rd_data_o   = ld_value;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Directed plus randomised bench for mem_access. A byte-wide memory
//   responder with configurable ack delay serves the controller port; a
//   byte-array reference memory predicts load results and store writes.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  aluop_i;
  logic [31:0] addr_i, data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_enable_i;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
  logic [31:0] rd_data_o;
  logic        stall_req, mc_req, mc_we, mc_ack;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata, mc_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic       mem_sync;
  logic       spur_ack;
  int         ack_dly;
  int         wcnt;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .aluop_i(aluop_i), .addr_i(addr_i),
    .data_i(data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o), .rd_data_o(rd_data_o),
    .stall_req(stall_req), .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_ack(mc_ack), .mc_rdata(mc_rdata)
  );

  // Memory responder: acks after ack_dly waiting cycles, 12-bit address space.
  assign mc_ack   = spur_ack || (mc_req && (wcnt >= ack_dly));
  assign mc_rdata = mem[mc_addr[11:0]];

  always @(posedge clk) begin
    if (mc_req && !mc_ack) wcnt <= wcnt + 1;
    else                   wcnt <= 0;
    if (mem_sync) begin
      for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
    end else if (mc_req && mc_ack && mc_we) begin
      mem[mc_addr[11:0]] <= mc_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] op);
    case (op)
      EX_LB, EX_LBU, EX_SB: return 1;
      EX_LH, EX_LHU, EX_SH: return 2;
      EX_LW, EX_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] raw;
    logic [31:0] ba;
    raw = 32'h0;
    for (int k = 0; k < nbytes(op); k++) begin
      ba  = a + 32'(k);
      raw = raw + (32'(ref_mem[ba[11:0]]) << (8 * k));
    end
    if (op == EX_LB && raw >= 32'd128)   raw = raw - 32'd256;
    if (op == EX_LH && raw >= 32'd32768) raw = raw - 32'd65536;
    return raw;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd,
                       input logic en, input int dly);
    int n, nb, stalls;
    logic st, done;
    logic [31:0] exp_v, ba;
    n     = nbytes(op);
    st    = (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
    exp_v = (n > 0 && !st) ? ref_load(op, addr) : 32'h0;
    ack_dly = dly;
    @(posedge clk); #1;
    aluop_i = op; addr_i = addr; data_i = data; rd_addr_i = rd; rd_enable_i = en;
    @(negedge clk);
    if (n == 0) begin
      chk("nop_stall", 32'(stall_req), 32'd0);
      chk("nop_req", 32'(mc_req), 32'd0);
      chk("nop_data", rd_data_o, data);
      chk("nop_rd", 32'(rd_addr_o), 32'(rd));
      chk("nop_en", 32'(rd_enable_o), 32'(en));
      return;
    end
    chk("idle_stall", 32'(stall_req), 32'd1);
    chk("idle_en", 32'(rd_enable_o), 32'd0);
    chk("idle_req", 32'(mc_req), 32'd0);
    nb = 0; stalls = 1; done = 1'b0;
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (stall_req) begin
        stalls++;
        chk("busy_en", 32'(rd_enable_o), 32'd0);
        chk("busy_req", 32'(mc_req), 32'd1);
        chk("busy_addr", mc_addr, addr + 32'(nb));
        chk("busy_we", 32'(mc_we), 32'(st));
        if (st) chk("busy_wdata", 32'(mc_wdata), (data >> (8 * nb)) & 32'hFF);
        if (mc_ack) nb++;
      end else begin
        done = 1'b1;
        chk("done_req", 32'(mc_req), 32'd0);
        chk("done_nbytes", 32'(nb), 32'(n));
        chk("done_stalls", 32'(stalls), 32'(n * (dly + 1) + 1));
        if (st) begin
          chk("done_st_en", 32'(rd_enable_o), 32'd0);
          chk("done_st_data", rd_data_o, 32'h0);
        end else begin
          chk("done_ld_en", 32'(rd_enable_o), 32'(en));
          chk("done_ld_rd", 32'(rd_addr_o), 32'(rd));
          chk("done_ld_data", rd_data_o, exp_v);
        end
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    if (st) begin
      for (int k = 0; k < n; k++) begin
        ba = addr + 32'(k);
        ref_mem[ba[11:0]] = 8'((data >> (8 * k)) & 32'hFF);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_req), 32'd0);
    chk({tag, "_req"}, 32'(mc_req), 32'd0);
    chk({tag, "_we"}, 32'(mc_we), 32'd0);
    chk({tag, "_addr"}, mc_addr, 32'd0);
    chk({tag, "_wdata"}, 32'(mc_wdata), 32'd0);
    chk({tag, "_en"}, 32'(rd_enable_o), 32'd0);
    chk({tag, "_rd"}, 32'(rd_addr_o), 32'd0);
    chk({tag, "_data"}, rd_data_o, 32'd0);
  endtask

  initial begin
    logic [3:0] ops [0:8];
    logic [31:0] sw_data, a;
    logic got;
    ops[0] = MEM_NOP; ops[1] = EX_LB; ops[2] = EX_LH; ops[3] = EX_LW;
    ops[4] = EX_LBU; ops[5] = EX_LHU; ops[6] = EX_SB; ops[7] = EX_SH; ops[8] = EX_SW;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    ref_mem[12'h000] = 8'h78; ref_mem[12'h001] = 8'h56;
    ref_mem[12'h002] = 8'h34; ref_mem[12'h003] = 8'h12;
    ref_mem[12'h020] = 8'h80;
    ref_mem[12'h040] = 8'h00; ref_mem[12'h041] = 8'h80;

    rst_n = 1'b0; mem_sync = 1'b1; spur_ack = 1'b0; ack_dly = 0;
    aluop_i = MEM_NOP; addr_i = 0; data_i = 0; rd_addr_i = 0; rd_enable_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; mem_sync = 1'b0;

    // LW 0x1000 -> 0x12345678, five stall cycles
    do_op(EX_LW, 32'h1000, 32'h0, 5'd7, 1'b1, 0);
    chk("lw_const", rd_data_o, 32'h12345678);
    do_op(EX_LB,  32'h20, 32'h0, 5'd1, 1'b1, 0);
    chk("lb_const", rd_data_o, 32'hFFFFFF80);
    do_op(EX_LBU, 32'h20, 32'h0, 5'd2, 1'b1, 0);
    chk("lbu_const", rd_data_o, 32'h00000080);
    do_op(EX_LH,  32'h40, 32'h0, 5'd3, 1'b1, 1);
    chk("lh_const", rd_data_o, 32'hFFFF8000);
    do_op(EX_LHU, 32'h40, 32'h0, 5'd4, 1'b1, 0);
    chk("lhu_const", rd_data_o, 32'h00008000);
    do_op(MEM_NOP, 32'h0, 32'h55, 5'd5, 1'b1, 0);
    do_op(EX_SH, 32'h3, 32'hDEADBEEF, 5'd9, 1'b1, 2);
    do_op(EX_LW, 32'h3, 32'h0, 5'd10, 1'b1, 0);

    // Reset while the second byte of an SW is waiting for its ack.
    a = 32'h180; sw_data = $urandom; ack_dly = 2; got = 1'b0;
    @(posedge clk); #1;
    aluop_i = EX_SW; addr_i = a; data_i = sw_data; rd_addr_i = 5'd6; rd_enable_i = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mc_req && mc_ack) got = 1'b1;
    end
    if (!got) chk("rst_sw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    aluop_i = MEM_NOP; addr_i = 0; data_i = 0; rd_addr_i = 0; rd_enable_i = 0;
    @(negedge clk);
    chk("rst_byte2_addr", mc_addr, a + 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    ref_mem[a[11:0]] = sw_data[7:0];
    do_op(EX_LB, a + 32'd1, 32'h0, 5'd11, 1'b1, 0);
    do_op(EX_LB, a, 32'h0, 5'd12, 1'b1, 0);

    // Address wrap across 2^32.
    do_op(EX_LW, 32'hFFFFFFFE, 32'h0, 5'd13, 1'b1, 0);

    // Spurious ack while idle.
    @(posedge clk); #1;
    aluop_i = MEM_NOP; data_i = 32'hA5A5_0001; rd_addr_i = 5'd14; rd_enable_i = 1'b1;
    spur_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("spur_stall", 32'(stall_req), 32'd0);
      chk("spur_req", 32'(mc_req), 32'd0);
      chk("spur_data", rd_data_o, 32'hA5A5_0001);
    end
    @(posedge clk); #1;
    spur_ack = 1'b0;
    do_op(EX_LHU, 32'h1000, 32'h0, 5'd15, 1'b1, 0);

    // Randomised back-to-back traffic.
    for (int t = 0; t < 40; t++) begin
      do_op(ops[$urandom_range(0, 8)],
            ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255)),
            32'($urandom), 5'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
